// File: rtl/rsa_pkg.sv
// Shared types for the RSA decryption datapath: controller states and default widths.
// Pure declarations; no timing or flow control of its own.
package rsa_pkg;

    localparam int WIDTH_DEF     = 1024;
    localparam int EXP_WIDTH_DEF = 1024;

    typedef enum logic [3:0] {
        IDLE,
        PRE,
        PRE_WAIT,
        TOMONT,
        SQ,
        MUL,
        NEXT,
        FROMMONT,
        DONE
    } state_t;

endpackage

// File: rtl/modexp_controller.sv
// Sequences m = c^d mod n over one shared Montgomery multiplier; latency EXP_WIDTH + popcount(d) + 2 mm ops
// plus precompute and per-step overhead. No backpressure: start is dropped unless idle, done is a one-cycle pulse.
module modexp_controller
    import rsa_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int EXP_WIDTH = EXP_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     c,
    input  logic [EXP_WIDTH-1:0] d,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     m,
    output logic                 pre_start,
    input  logic                 pre_done,
    input  logic [WIDTH-1:0]     r,
    input  logic [WIDTH-1:0]     t,
    output logic                 mm_start,
    output logic [WIDTH-1:0]     mm_a,
    output logic [WIDTH-1:0]     mm_b,
    input  logic                 mm_done,
    input  logic [WIDTH-1:0]     mm_result
);

    localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
    localparam logic [IW-1:0]    IDX_MAX = IW'(EXP_WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t               state;
    logic [WIDTH-1:0]     c_q;
    logic [EXP_WIDTH-1:0] d_q;
    logic [WIDTH-1:0]     r_q;
    logic [WIDTH-1:0]     cbar;
    logic [WIDTH-1:0]     x;
    logic [IW-1:0]        idx;

    // A completion coinciding with our own start pulse cannot belong to the op just issued.
    logic mm_ack;
    assign mm_ack = mm_done && !mm_start;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            m         <= '0;
            pre_start <= 1'b0;
            mm_start  <= 1'b0;
            mm_a      <= '0;
            mm_b      <= '0;
            c_q       <= '0;
            d_q       <= '0;
            r_q       <= '0;
            cbar      <= '0;
            x         <= '0;
            idx       <= IDX_MAX;
        end else begin
            pre_start <= 1'b0;
            mm_start  <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    c_q       <= c;
                    d_q       <= d;
                    idx       <= IDX_MAX;
                    busy      <= 1'b1;
                    pre_start <= 1'b1;
                    state     <= PRE;
                end
                PRE: state <= PRE_WAIT;
                // t goes straight into the B operand register, which holds it for the whole conversion op.
                PRE_WAIT: if (pre_done) begin
                    r_q      <= r;
                    mm_a     <= c_q;
                    mm_b     <= t;
                    mm_start <= 1'b1;
                    state    <= TOMONT;
                end
                TOMONT: if (mm_ack) begin
                    cbar     <= mm_result;
                    x        <= r_q;
                    mm_a     <= r_q;
                    mm_b     <= r_q;
                    mm_start <= 1'b1;
                    state    <= SQ;
                end
                SQ: if (mm_ack) begin
                    x <= mm_result;
                    if (d_q[idx]) begin
                        mm_a     <= mm_result;
                        mm_b     <= cbar;
                        mm_start <= 1'b1;
                        state    <= MUL;
                    end else begin
                        state <= NEXT;
                    end
                end
                MUL: if (mm_ack) begin
                    x     <= mm_result;
                    state <= NEXT;
                end
                NEXT: begin
                    mm_a     <= x;
                    mm_start <= 1'b1;
                    if (idx == '0) begin
                        mm_b  <= ONE;
                        state <= FROMMONT;
                    end else begin
                        idx   <= idx - 1'b1;
                        mm_b  <= x;
                        state <= SQ;
                    end
                end
                FROMMONT: if (mm_ack) begin
                    m     <= mm_result;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_modexp_controller.sv
// Scoreboard bench for modexp_controller at WIDTH=EXP_WIDTH=8, n=187, with behavioural precompute and Montgomery models.
module tb_modexp_controller;

    localparam int N  = 187;
    localparam int RV = 69;
    localparam int TV = 86;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] c = '0;
    logic [7:0] d = '0;
    logic       busy, done, pre_start, mm_start;
    logic [7:0] m, mm_a, mm_b;
    logic       pre_done = 1'b0;
    logic       mm_done = 1'b0;
    logic [7:0] r = 8'(RV);
    logic [7:0] t = 8'(TV);
    logic [7:0] mm_result = '0;

    always #5 clk = ~clk;

    modexp_controller #(.WIDTH(8), .EXP_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .c(c), .d(d),
        .busy(busy), .done(done), .m(m),
        .pre_start(pre_start), .pre_done(pre_done), .r(r), .t(t),
        .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b),
        .mm_done(mm_done), .mm_result(mm_result)
    );

    typedef struct {
        int m;
        int ops;
    } exp_t;
    exp_t exp_q[$];

    int compared = 0;
    int mismatched = 0;

    task automatic check(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // a*b*R^-1 mod n, found by searching for y with y*R == a*b (mod n)
    function automatic int mont(input int a, input int b);
        for (int y = 0; y < N; y++)
            if ((y * 256) % N == (a * b) % N) return y;
        return -1;
    endfunction

    // Montgomery multiplier model
    int         mm_lat = 3;
    bit         mm_rand = 1'b0;
    int         mm_cnt = 0;
    bit         mm_act = 1'b0;
    bit         mm_abort = 1'b0;
    int         ops_total = 0;
    logic [7:0] hold_a = '0;
    logic [7:0] hold_b = '0;

    always @(negedge clk) begin
        mm_done = 1'b0;
        if (mm_start && !reset) begin
            ops_total++;
            check("busy_during_mm", int'(busy), 1);
        end
        if (mm_act) begin
            if (reset) mm_abort = 1'b1;
            if (!mm_abort) begin
                check("mm_a_stable", int'(mm_a), int'(hold_a));
                check("mm_b_stable", int'(mm_b), int'(hold_b));
            end
            mm_cnt--;
            if (mm_cnt == 0) begin
                mm_done   = 1'b1;
                mm_result = 8'(mont(int'(hold_a), int'(hold_b)));
                mm_act    = 1'b0;
            end
        end else if (mm_start && !reset) begin
            hold_a   = mm_a;
            hold_b   = mm_b;
            mm_cnt   = mm_rand ? int'($urandom_range(10, 1)) : mm_lat;
            mm_act   = 1'b1;
            mm_abort = 1'b0;
        end
    end

    // Precompute model
    int pre_lat = 1;
    int pre_cnt = 0;
    bit pre_act = 1'b0;
    int pre_total = 0;

    always @(negedge clk) begin
        pre_done = 1'b0;
        if (pre_start && !reset) begin
            pre_total++;
            check("busy_during_pre", int'(busy), 1);
        end
        if (pre_act) begin
            pre_cnt--;
            if (pre_cnt == 0) begin
                pre_done = 1'b1;
                pre_act  = 1'b0;
            end
        end else if (pre_start && !reset) begin
            pre_cnt = pre_lat;
            pre_act = 1'b1;
        end
    end

    // Monitor: consumes one expectation per done pulse
    bit   prev_done = 1'b0;
    int   ops_base = 0;
    int   pre_base = 0;
    exp_t e;

    always @(negedge clk) begin
        if (reset) begin
            ops_base = ops_total;
            pre_base = pre_total;
        end else if (done) begin
            check("done_single_pulse", int'(prev_done), 0);
            check("busy_at_done", int'(busy), 1);
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_done: got m=%0d, required no done", m);
            end else begin
                e = exp_q.pop_front();
                check("m", int'(m), e.m);
                check("mm_op_count", ops_total - ops_base, e.ops);
                check("pre_start_pulses", pre_total - pre_base, 1);
            end
            ops_base = ops_total;
            pre_base = pre_total;
        end
        prev_done = done;
    end

    task automatic expect_run(input int em, input int eops);
        exp_t x;
        x.m   = em;
        x.ops = eops;
        exp_q.push_back(x);
    endtask

    task automatic run(input int cv, input int dv, input int em, input int eops);
        expect_run(em, eops);
        @(negedge clk);
        start = 1'b1;
        c     = 8'(cv);
        d     = 8'(dv);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) return;
        end
        compared++;
        mismatched++;
        $display("FAIL wait_done: got no done within 3000 cycles, required a done pulse");
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_m"}, int'(m), 0);
        check({tag, "_pre_start"}, int'(pre_start), 0);
        check({tag, "_mm_start"}, int'(mm_start), 0);
        check({tag, "_mm_a"}, int'(mm_a), 0);
        check({tag, "_mm_b"}, int'(mm_b), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // basic decrypt, zero exponent, all-ones exponent
        run(125, 8'h6B, 5, 15);
        wait_done();
        run(125, 8'h00, 1, 10);
        wait_done();
        run(2, 8'hFF, 43, 18);
        wait_done();

        // start mid-run and in the done cycle ignored; start one cycle later accepted
        run(125, 8'h6B, 5, 15);
        repeat (30) @(negedge clk);
        start = 1'b1;
        c     = 8'd2;
        d     = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        start = 1'b1;
        c     = 8'd3;
        d     = 8'h05;
        @(negedge clk);
        check("busy_after_done", int'(busy), 0);
        check("done_after_done", int'(done), 0);
        check("m_held_after_done", int'(m), 5);
        expect_run(1, 10);
        c = 8'd125;
        d = 8'h00;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // reset with the first SQ op outstanding; the aborted op's done lands after reset
        mm_lat = 6;
        run(125, 8'h6B, 5, 15);
        for (int i = 0; i < 500 && (ops_total - ops_base) < 2; i++) @(negedge clk);
        check("ops_before_reset", ops_total - ops_base, 2);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_all_zero("midreset");
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("busy_after_stray", int'(busy), 0);
        check("m_after_stray", int'(m), 0);
        check("no_mm_after_reset", ops_total - ops_base, 0);
        mm_lat = 3;
        run(125, 8'h6B, 5, 15);
        wait_done();

        // slow precompute and randomised multiplier latency
        pre_lat = 20;
        mm_rand = 1'b1;
        run(125, 8'h6B, 5, 15);
        wait_done();
        repeat (3) @(negedge clk);

        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/modexp_controller.md
Name: modexp_controller

Overview:
- Sequences one RSA decryption m = c^d mod n.
- Starts the secondary-input precompute unit (n0', r = R mod n, t = R^2 mod n) and waits for it to finish.
- Then drives a single shared Montgomery multiplier through a left-to-right square-and-multiply schedule, including conversion into and out of the Montgomery domain.
- Sits between the decryption top level, the precompute unit and the Montgomery multiplier. n and n0p are wired straight to the multiplier, not through this block.

Parameters:
- WIDTH, 1024, operand/modulus width; R = 2^WIDTH.
- EXP_WIDTH, 1024, width of private exponent d.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle request; accepted only in IDLE
- c  in  WIDTH  ciphertext, sampled on accepted start
- d  in  EXP_WIDTH  exponent, sampled on accepted start
- busy  out  1  high from cycle after accepted start through done cycle
- done  out  1  one-cycle pulse; m valid
- m  out  WIDTH  plaintext, held until next accepted start
- pre_start  out  1  one-cycle pulse to precompute unit
- pre_done  in  1  one-cycle pulse from precompute unit; r, t valid
- r  in  WIDTH  R mod n, latched on pre_done
- t  in  WIDTH  R^2 mod n, latched on pre_done
- mm_start  out  1  one-cycle pulse to Montgomery multiplier
- mm_a  out  WIDTH  operand A, stable from mm_start until mm_done
- mm_b  out  WIDTH  operand B, stable from mm_start until mm_done
- mm_done  in  1  one-cycle pulse; mm_result = A*B*R^-1 mod n
- mm_result  in  WIDTH  multiplier result

Behaviour:
- Reset values: busy=0, done=0, m=0, pre_start=0, mm_start=0, mm_a=0, mm_b=0. Internal registers cleared; bit index = EXP_WIDTH-1; state=IDLE.
- Reset mid-operation: return to IDLE next edge. Late pre_done/mm_done pulses arriving after reset are ignored.
- Internal registers: c_q, d_q, r_q, t_q, cbar (c in Montgomery domain), x (accumulator), idx (bit counter).
- IDLE: on start, latch c, d; idx = EXP_WIDTH-1; go PRE.
- PRE: assert pre_start for exactly one cycle; go PRE_WAIT.
- PRE_WAIT: on pre_done, latch r_q=r, t_q=t; go TOMONT. Precompute guarantees pre_done no earlier than the cycle after pre_start.
- TOMONT: issue mm(c_q, t_q). On mm_done: cbar = mm_result, x = r_q; go SQ.
- SQ: issue mm(x, x). On mm_done: x = mm_result. If d_q[idx]=1 go MUL, else go NEXT.
- MUL: issue mm(x, cbar). On mm_done: x = mm_result; go NEXT.
- NEXT: if idx==0 go FROMMONT; else idx = idx-1, go SQ. Single cycle, no wrap; the counter never decrements below 0.
- FROMMONT: issue mm(x, 1), with B zero-extended to WIDTH. On mm_done: m = mm_result; go DONE.
- DONE: done=1 for one cycle, busy drops the next cycle; go IDLE.
- "Issue" rules:
  - mm_start is high in the first cycle of the sub-state only.
  - mm_a/mm_b are driven from the entry cycle and held until mm_done is sampled.
  - A one-cycle gap between consecutive mm ops is permitted.
- mm_done or pre_done outside the corresponding wait: ignored.
- start while busy: ignored. start in the same cycle as the done pulse: ignored. start in IDLE the cycle after done: accepted.
- Every exponent bit is processed, leading zeros included, for constant schedule length.
- Multiplier op count = EXP_WIDTH + popcount(d) + 2.
- d=0: result is mm(r,1)·… = 1 mod n, so m=1 for n>1.

Decomposition:
- Shared package rsa_pkg: state enum typedef (IDLE, PRE, PRE_WAIT, TOMONT, SQ, MUL, NEXT, FROMMONT, DONE) and default WIDTH/EXP_WIDTH constants.
- No sub-module needed. A small mm_issue helper (start-pulse generator plus operand hold) is optional, named mm_issue.
- Bench uses a behavioural Montgomery model with configurable latency.

Test Plan (WIDTH=8, EXP_WIDTH=8, n=187, R=256, r=69, t=86, behavioural mm latency 3):
- Basic decrypt: c=125, d=0x6B -> m=5, one done pulse. Exactly 15 mm_start pulses: 1 to-domain, 8 SQ, 5 MUL, 1 from-domain. busy high throughout.
- d=0x00, c=125 -> m=1. 10 mm ops. No MUL state visited.
- d=0xFF, c=2 -> m = 2^255 mod 187 per reference model. 18 mm ops. mm_a/mm_b stable during each op.
- start pulsed again mid-run and in the done cycle -> ignored, result unchanged. start one cycle after done -> new run accepted.
- reset asserted during SQ with an mm op outstanding -> all outputs 0 next cycle. Stray mm_done afterward ignored. Subsequent run with c=125, d=0x6B yields m=5.
- pre_done delayed 20 cycles and mm latency randomized 1–10 -> identical m=5. pre_start is exactly one pulse.
